// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath widths, zero-register index and typedefs
package cpu_pkg;

    localparam int DATA_W  = 64;
    localparam int IDX_W   = 5;
    localparam int XZR_IDX = 31;

    typedef logic [IDX_W-1:0]  reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one registered read port with XZR forcing
// and optional write-through under REGFILE_BYPASS_EN
module regfile_read_port
    import cpu_pkg::*;
#(
    parameter int N = DATA_W,
    parameter int R = IDX_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rd_req,
    input  logic [R-1:0]                  raddr,
    input  logic [XZR_IDX-1:0][N-1:0]     mem,
    input  logic                          wr_en,
    input  logic [R-1:0]                  waddr,
    input  logic [N-1:0]                  wdata,
    output logic [N-1:0]                  rdata
);

    localparam logic [R-1:0] ZERO_IDX = R'(XZR_IDX);

    logic [N-1:0] rdata_d;
    logic [N-1:0] rdata_q;

    always_comb begin
        rdata_d = rdata_q;
        if (rd_req) begin
            if (raddr == ZERO_IDX) begin
                rdata_d = '0;
            end else begin
                rdata_d = mem[raddr];
`ifdef REGFILE_BYPASS_EN
                // Same-edge write to this entry wins over the stored copy
                if (wr_en && (waddr == raddr)) begin
                    rdata_d = wdata;
                end
`endif
            end
        end
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_wr;
    assign unused_wr = ^{wr_en, waddr, wdata};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 32x64 register file, two registered reads, one write,
// entry 31 reads as zero; REGFILE_BYPASS_EN enables same-edge write-through
module regfile_2r1w
    import cpu_pkg::*;
#(
    parameter int N = DATA_W,
    parameter int R = IDX_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rd_req,
    input  logic [R-1:0] ReadReg1,
    input  logic [R-1:0] ReadReg2,
    input  logic         RegWrite,
    input  logic [R-1:0] WriteReg,
    input  logic [N-1:0] WriteData,
    output logic [N-1:0] ReadData1,
    output logic [N-1:0] ReadData2,
    output logic         rd_valid
);

    localparam logic [R-1:0] ZERO_IDX = R'(XZR_IDX);

    // Entry 31 has no storage; only 0..30 are held
    logic [XZR_IDX-1:0][N-1:0] mem_d;
    logic [XZR_IDX-1:0][N-1:0] mem_q;
    logic                      rd_valid_d;
    logic                      rd_valid_q;
    logic                      wr_en;

    assign wr_en = RegWrite && (WriteReg != ZERO_IDX);

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[WriteReg] = WriteData;
        end
        rd_valid_d = rd_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    regfile_read_port #(.N(N), .R(R)) u_port1 (
        .clk   (clk),
        .rst_n (rst_n),
        .rd_req(rd_req),
        .raddr (ReadReg1),
        .mem   (mem_q),
        .wr_en (wr_en),
        .waddr (WriteReg),
        .wdata (WriteData),
        .rdata (ReadData1)
    );

    regfile_read_port #(.N(N), .R(R)) u_port2 (
        .clk   (clk),
        .rst_n (rst_n),
        .rd_req(rd_req),
        .raddr (ReadReg2),
        .mem   (mem_q),
        .wr_en (wr_en),
        .waddr (WriteReg),
        .wdata (WriteData),
        .rdata (ReadData2)
    );

    assign rd_valid = rd_valid_q;

endmodule
